gat_layer_scheduler: RTL and testbench

- Run-level controller between the register bank and the GAT compute core.
- Waits for the host BRAM-load handshake flags, latches the layer select, and pulses a start into the core.
- Counts per-subgraph completions, then raises gat_ready. A watchdog catches a stalled core.
- Provides run statistics on the three 32-bit debug words.

---
 rtl/gat_layer_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_gat_layer_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_layer_scheduler.sv
// gat_layer_scheduler
// Run-level controller between the register bank and the GAT compute core.
// Waits for the host BRAM-load flags, latches the layer select, pulses a start
// into the core, counts per-subgraph completions, then raises gat_ready.
// A watchdog flags a core that stops producing completions.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   gat_layer                   layer select (0 = layer 1, 1 = layer 2)
//   h_data_bram_load_done       host finished H data BRAM (level)
//   h_node_info_bram_load_done  host finished node-info BRAM (level)
//   wgt_bram_load_done          host finished weight BRAM (level)
//   core_subgraph_done          1-cycle pulse per completed subgraph
//   core_busy                   core pipeline non-empty
//   core_start                  1-cycle start pulse to core
//   core_layer                  layer latched at start, stable for the run
//   gat_ready                   run complete
//   gat_error                   watchdog expired
//   gat_debug_1                 RUN+FLUSH cycles of the last completed run
//   gat_debug_2                 {state, core_layer, gat_error, 0, subgraph_cnt}
//   gat_debug_3                 completed runs since reset (wraps)
module gat_layer_scheduler #(
    parameter int unsigned TOP_WIDTH      = 32,
    parameter int unsigned NUM_SUBGRAPHS  = 2708,
    parameter int unsigned SUBGRAPH_CNT_W = $clog2(NUM_SUBGRAPHS + 1),
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 gat_layer,
    input  logic                 h_data_bram_load_done,
    input  logic                 h_node_info_bram_load_done,
    input  logic                 wgt_bram_load_done,
    input  logic                 core_subgraph_done,
    input  logic                 core_busy,
    output logic                 core_start,
    output logic                 core_layer,
    output logic                 gat_ready,
    output logic                 gat_error,
    output logic [TOP_WIDTH-1:0] gat_debug_1,
    output logic [TOP_WIDTH-1:0] gat_debug_2,
    output logic [TOP_WIDTH-1:0] gat_debug_3
);

    localparam int unsigned PAD_W = TOP_WIDTH - 5 - SUBGRAPH_CNT_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_e;

    state_e                      state_q, state_d;
    logic                        core_start_q, core_start_d;
    logic                        core_layer_q, core_layer_d;
    logic                        gat_ready_q, gat_ready_d;
    logic                        gat_error_q, gat_error_d;
    logic [SUBGRAPH_CNT_W-1:0]   sg_cnt_q, sg_cnt_d;
    logic [TIMEOUT_W-1:0]        wdog_q, wdog_d;
    logic [TOP_WIDTH-1:0]        run_cyc_q, run_cyc_d;
    logic [TOP_WIDTH-1:0]        dbg1_q, dbg1_d;
    logic [TOP_WIDTH-1:0]        runs_q, runs_d;

    logic                        layer_sel_c;
    logic                        load_ok_c;
    logic [TOP_WIDTH-1:0]        run_cyc_inc_c;

    // Layer 2 takes H from layer-1 features, so only the weights must be loaded.
    // Outside IDLE the latched layer decides, since gat_layer is ignored there.
    always_comb begin
        layer_sel_c = (state_q == S_IDLE) ? gat_layer : core_layer_q;
        load_ok_c   = layer_sel_c ? wgt_bram_load_done
                                  : (h_data_bram_load_done & h_node_info_bram_load_done
                                     & wgt_bram_load_done);
    end

    // Saturating run-length counter increment.
    assign run_cyc_inc_c = (run_cyc_q == '1) ? run_cyc_q : run_cyc_q + TOP_WIDTH'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        core_start_d = 1'b0;
        core_layer_d = core_layer_q;
        gat_ready_d  = gat_ready_q;
        gat_error_d  = gat_error_q;
        sg_cnt_d     = sg_cnt_q;
        wdog_d       = wdog_q;
        run_cyc_d    = run_cyc_q;
        dbg1_d       = dbg1_q;
        runs_d       = runs_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_ok_c) begin
                    core_layer_d = gat_layer;
                    core_start_d = 1'b1;
                    gat_error_d  = 1'b0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                sg_cnt_d  = '0;
                wdog_d    = '0;
                run_cyc_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                run_cyc_d = run_cyc_inc_c;
                // A completion in the same cycle as the limit clears the watchdog.
                if (core_subgraph_done) begin
                    sg_cnt_d = sg_cnt_q + SUBGRAPH_CNT_W'(1);
                    wdog_d   = '0;
                    if (sg_cnt_d == SUBGRAPH_CNT_W'(NUM_SUBGRAPHS)) begin
                        state_d = S_FLUSH;
                    end
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                    if (wdog_d == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                        gat_error_d = 1'b1;
                        gat_ready_d = 1'b0;
                        state_d     = S_ERROR;
                    end
                end
            end
            S_FLUSH: begin
                run_cyc_d = run_cyc_inc_c;
                if (!core_busy) begin
                    dbg1_d      = run_cyc_inc_c;
                    runs_d      = runs_q + TOP_WIDTH'(1);
                    gat_ready_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                    if (wdog_d == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                        gat_error_d = 1'b1;
                        gat_ready_d = 1'b0;
                        state_d     = S_ERROR;
                    end
                end
            end
            S_DONE: begin
                // Host must drop its flags before another run can start.
                if (!load_ok_c) begin
                    gat_ready_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_ERROR: begin
                if (!load_ok_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            core_start_q <= 1'b0;
            core_layer_q <= 1'b0;
            gat_ready_q  <= 1'b0;
            gat_error_q  <= 1'b0;
            sg_cnt_q     <= '0;
            wdog_q       <= '0;
            run_cyc_q    <= '0;
            dbg1_q       <= '0;
            runs_q       <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            core_layer_q <= core_layer_d;
            gat_ready_q  <= gat_ready_d;
            gat_error_q  <= gat_error_d;
            sg_cnt_q     <= sg_cnt_d;
            wdog_q       <= wdog_d;
            run_cyc_q    <= run_cyc_d;
            dbg1_q       <= dbg1_d;
            runs_q       <= runs_d;
        end
    end

    assign core_start  = core_start_q;
    assign core_layer  = core_layer_q;
    assign gat_ready   = gat_ready_q;
    assign gat_error   = gat_error_q;
    assign gat_debug_1 = dbg1_q;
    assign gat_debug_2 = {state_q, core_layer_q, gat_error_q, PAD_W'(0), sg_cnt_q};
    assign gat_debug_3 = runs_q;

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Testbench for gat_layer_scheduler: directed scenarios plus randomized runs.
// Expected outcomes are computed from the gap/busy profile of each run.
module tb_gat_layer_scheduler;

    localparam int unsigned TW = 32;
    localparam int unsigned NS = 4;
    localparam int unsigned TO = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    logic          clk;
    logic          rst_n;
    logic          gat_layer;
    logic          h_data_bram_load_done;
    logic          h_node_info_bram_load_done;
    logic          wgt_bram_load_done;
    logic          core_subgraph_done;
    logic          core_busy;
    logic          core_start;
    logic          core_layer;
    logic          gat_ready;
    logic          gat_error;
    logic [TW-1:0] gat_debug_1;
    logic [TW-1:0] gat_debug_2;
    logic [TW-1:0] gat_debug_3;

    int n_tests = 0;
    int n_fail  = 0;
    int runs_exp = 0;

    gat_layer_scheduler #(
        .TOP_WIDTH      (TW),
        .NUM_SUBGRAPHS  (NS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .gat_layer                  (gat_layer),
        .h_data_bram_load_done      (h_data_bram_load_done),
        .h_node_info_bram_load_done (h_node_info_bram_load_done),
        .wgt_bram_load_done         (wgt_bram_load_done),
        .core_subgraph_done         (core_subgraph_done),
        .core_busy                  (core_busy),
        .core_start                 (core_start),
        .core_layer                 (core_layer),
        .gat_ready                  (gat_ready),
        .gat_error                  (gat_error),
        .gat_debug_1                (gat_debug_1),
        .gat_debug_2                (gat_debug_2),
        .gat_debug_3                (gat_debug_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input bit layer);
        h_data_bram_load_done      = !layer;
        h_node_info_bram_load_done = !layer;
        wgt_bram_load_done         = 1'b1;
    endtask

    // Flags and layer select are don't-care while a run is in flight.
    task automatic scramble();
        gat_layer                  = 1'($urandom_range(0, 1));
        h_data_bram_load_done      = 1'($urandom_range(0, 1));
        h_node_info_bram_load_done = 1'($urandom_range(0, 1));
        wgt_bram_load_done         = 1'($urandom_range(0, 1));
    endtask

    task automatic start_run(input bit layer);
        gat_layer = layer;
        set_flags(layer);
        tick();
        chk("start_pulse", 32'(core_start), 32'd1);
        chk("start_layer", 32'(core_layer), 32'(layer));
        chk("start_err_clr", 32'(gat_error), 32'd0);
        chk("start_state", 32'(gat_debug_2[31:29]), 32'(ST_START));
        tick();
        chk("start_once", 32'(core_start), 32'd0);
        chk("run_state", 32'(gat_debug_2[31:29]), 32'(ST_RUN));
    endtask

    // g[k] = idle cycles before completion k; b = busy cycles after the last one.
    task automatic run_job(input bit layer, input int g[NS], input int b, output bit err);
        int run_ticks;
        run_ticks = 0;
        err = 1'b0;
        core_busy = 1'b0;
        start_run(layer);
        for (int k = 0; k < int'(NS) && !err; k++) begin
            for (int i = 1; i <= g[k]; i++) begin
                core_subgraph_done = 1'b0;
                scramble();
                tick();
                run_ticks++;
                if (i == int'(TO)) begin
                    err = 1'b1;
                    break;
                end
            end
            if (!err) begin
                core_subgraph_done = 1'b1;
                core_busy = (k == int'(NS) - 1) && (b > 0);
                scramble();
                tick();
                run_ticks++;
                core_subgraph_done = 1'b0;
                chk("cnt_after_pulse", 32'(gat_debug_2[26:0]), 32'(k + 1));
                chk("layer_hold", 32'(core_layer), 32'(layer));
                chk("state_after_pulse", 32'(gat_debug_2[31:29]),
                    (k == int'(NS) - 1) ? 32'(ST_FLUSH) : 32'(ST_RUN));
                chk("no_early_ready", 32'(gat_ready), 32'd0);
            end
        end
        gat_layer = layer;
        set_flags(layer);
        if (err) begin
            chk("wdog_error", 32'(gat_error), 32'd1);
            chk("wdog_no_ready", 32'(gat_ready), 32'd0);
            chk("wdog_state", 32'(gat_debug_2[31:29]), 32'(ST_ERROR));
            return;
        end
        for (int j = 0; j < b; j++) begin
            chk("flush_state", 32'(gat_debug_2[31:29]), 32'(ST_FLUSH));
            chk("flush_no_ready", 32'(gat_ready), 32'd0);
            chk("flush_cnt", 32'(gat_debug_2[26:0]), 32'(NS));
            core_busy = 1'b1;
            core_subgraph_done = 1'($urandom_range(0, 1));
            tick();
        end
        core_subgraph_done = 1'b0;
        core_busy = 1'b0;
        chk("flush_last", 32'(gat_debug_2[31:29]), 32'(ST_FLUSH));
        tick();
        runs_exp++;
        chk("ready", 32'(gat_ready), 32'd1);
        chk("done_state", 32'(gat_debug_2[31:29]), 32'(ST_DONE));
        chk("done_cnt", 32'(gat_debug_2[26:0]), 32'(NS));
        chk("run_cycles", gat_debug_1, 32'(run_ticks + b + 1));
        chk("run_count", gat_debug_3, 32'(runs_exp));
        chk("done_no_err", 32'(gat_error), 32'd0);
    endtask

    // Drop one flag that the latched layer depends on; ready falls next cycle.
    task automatic release_flags(input bit layer);
        int which;
        which = layer ? 2 : int'($urandom_range(0, 2));
        case (which)
            0:       h_data_bram_load_done = 1'b0;
            1:       h_node_info_bram_load_done = 1'b0;
            default: wgt_bram_load_done = 1'b0;
        endcase
        tick();
        chk("release_ready", 32'(gat_ready), 32'd0);
        chk("release_state", 32'(gat_debug_2[31:29]), 32'(ST_IDLE));
    endtask

    task automatic clear_error();
        h_data_bram_load_done      = 1'b0;
        h_node_info_bram_load_done = 1'b0;
        wgt_bram_load_done         = 1'b0;
        tick();
        chk("err_idle_state", 32'(gat_debug_2[31:29]), 32'(ST_IDLE));
        chk("err_sticky", 32'(gat_error), 32'd1);
        chk("err_idle_ready", 32'(gat_ready), 32'd0);
    endtask

    initial begin
        int  g[NS];
        bit  err;
        bit  lyr;
        int  b;

        rst_n = 1'b0;
        gat_layer = 1'b0;
        h_data_bram_load_done = 1'b0;
        h_node_info_bram_load_done = 1'b0;
        wgt_bram_load_done = 1'b0;
        core_subgraph_done = 1'b0;
        core_busy = 1'b0;
        tick();
        tick();
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_layer", 32'(core_layer), 32'd0);
        chk("rst_ready", 32'(gat_ready), 32'd0);
        chk("rst_error", 32'(gat_error), 32'd0);
        chk("rst_dbg1", gat_debug_1, 32'd0);
        chk("rst_dbg2", gat_debug_2, 32'd0);
        chk("rst_dbg3", gat_debug_3, 32'd0);
        rst_n = 1'b1;
        tick();

        // Layer-1 nominal: completions three cycles apart.
        g = '{2, 2, 2, 2};
        run_job(1'b0, g, 0, err);
        release_flags(1'b0);

        // Layer-2 gating: only the weight flag is needed.
        g = '{1, 0, 3, 1};
        run_job(1'b1, g, 2, err);
        release_flags(1'b1);
        gat_layer = 1'b0;
        h_data_bram_load_done = 1'b0;
        h_node_info_bram_load_done = 1'b0;
        wgt_bram_load_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("l1_gated_start", 32'(core_start), 32'd0);
            chk("l1_gated_state", 32'(gat_debug_2[31:29]), 32'(ST_IDLE));
        end
        wgt_bram_load_done = 1'b0;
        tick();

        // Watchdog: two completions then silence.
        g = '{1, 1, int'(TO) + 3, 0};
        run_job(1'b0, g, 0, err);
        clear_error();

        // Completion exactly at the watchdog limit must win.
        g = '{int'(TO) - 1, 0, int'(TO) - 1, int'(TO) - 1};
        run_job(1'b0, g, 0, err);
        release_flags(1'b0);

        // Flush hold with a long busy tail.
        g = '{0, 1, 0, 2};
        run_job(1'b1, g, 10, err);

        // Handshake release: flags held high must not retrigger.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_no_start", 32'(core_start), 32'd0);
            chk("hold_ready", 32'(gat_ready), 32'd1);
        end
        release_flags(1'b1);
        g = '{3, 3, 3, 3};
        run_job(1'b1, g, 1, err);
        release_flags(1'b1);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            lyr = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'(NS); k++) begin
                g[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 1))
                                                   : int'($urandom_range(0, 6));
            end
            b = int'($urandom_range(0, 6));
            run_job(lyr, g, b, err);
            if (err) clear_error();
            else release_flags(lyr);
        end

        // Reset in the middle of a run.
        start_run(1'b0);
        for (int k = 0; k < 2; k++) begin
            core_subgraph_done = 1'b1;
            tick();
            core_subgraph_done = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        runs_exp = 0;
        chk("mid_rst_start", 32'(core_start), 32'd0);
        chk("mid_rst_layer", 32'(core_layer), 32'd0);
        chk("mid_rst_ready", 32'(gat_ready), 32'd0);
        chk("mid_rst_error", 32'(gat_error), 32'd0);
        chk("mid_rst_dbg1", gat_debug_1, 32'd0);
        chk("mid_rst_dbg2", gat_debug_2, 32'd0);
        chk("mid_rst_dbg3", gat_debug_3, 32'(runs_exp));
        h_data_bram_load_done = 1'b0;
        h_node_info_bram_load_done = 1'b0;
        wgt_bram_load_done = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            core_subgraph_done = 1'b1;
            tick();
            core_subgraph_done = 1'b0;
            chk("post_rst_dbg2", gat_debug_2, 32'd0);
            chk("post_rst_start", 32'(core_start), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
